// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl - top-level game sequencer for the Pac-Man core.
//
// Tracks game state, level and spare lives. Sequences the reload handshake
// for the board/item channels, runs the timed READY and DYING phases off
// the frame tick, and grants a single bonus life per game at a score
// threshold.
//
// Ports:
//   i_clk, i_rst_n   system clock, asynchronous active-low reset
//   i_game_start     start / continue pulse
//   i_game_pause     pause toggle pulse
//   i_tick           frame tick (one-cycle pulse)
//   i_reload_done    per-channel reload-complete (pulse or level)
//   i_pacman_eaten   pacman caught by a ghost
//   i_dot_clear      all dots eaten
//   i_score          current score
//   o_game_state     encoded state (see table)
//   o_reload_req     per-channel reload request
//   o_actor_reload   one-cycle pulse: reset ghost/pacman positions
//   o_level          current level (saturating)
//   o_lives          remaining spare lives
//   o_extra_life     one-cycle pulse when the bonus life is granted
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | 0: waiting for start
// RELOAD   | 1: board/item channels reloading, waiting for all done
// READY    | 2: timed get-ready pause before play
// PLAY     | 3: game running
// PAUSE    | 4: frozen until the next pause pulse
// DYING    | 5: timed death animation
// CLEAR    | 6: level cleared, waiting for start of the next level
// GAMEOVER | 7: no lives left, waiting for start

module game_flow_ctrl #(
    parameter int N_RELOAD         = 2,
    parameter int LIVES_INIT       = 3,
    parameter int MAX_LIVES        = 9,
    parameter int LEVEL_W          = 8,
    parameter int MAX_LEVEL        = 255,
    parameter int READY_TICKS      = 120,
    parameter int DEATH_TICKS      = 90,
    parameter int SCORE_W          = 20,
    parameter int EXTRA_LIFE_SCORE = 10000
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_game_start,
    input  logic                i_game_pause,
    input  logic                i_tick,
    input  logic [N_RELOAD-1:0] i_reload_done,
    input  logic                i_pacman_eaten,
    input  logic                i_dot_clear,
    input  logic [SCORE_W-1:0]  i_score,
    output logic [3:0]          o_game_state,
    output logic [N_RELOAD-1:0] o_reload_req,
    output logic                o_actor_reload,
    output logic [LEVEL_W-1:0]  o_level,
    output logic [3:0]          o_lives,
    output logic                o_extra_life
);

    localparam int TMR_MAX = (READY_TICKS > DEATH_TICKS) ? READY_TICKS : DEATH_TICKS;
    localparam int TMR_W   = (TMR_MAX > 0) ? $clog2(TMR_MAX + 1) : 1;

    localparam logic [TMR_W-1:0]    READY_LOAD = TMR_W'(READY_TICKS);
    localparam logic [TMR_W-1:0]    DEATH_LOAD = TMR_W'(DEATH_TICKS);
    localparam logic [N_RELOAD-1:0] ALL_DONE   = '1;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_RELOAD   = 4'd1,
        S_READY    = 4'd2,
        S_PLAY     = 4'd3,
        S_PAUSE    = 4'd4,
        S_DYING    = 4'd5,
        S_CLEAR    = 4'd6,
        S_GAMEOVER = 4'd7
    } state_t;

    state_t              state_q, state_d;
    logic [N_RELOAD-1:0] req_q, req_d;
    logic [N_RELOAD-1:0] mask_q, mask_d;
    logic [LEVEL_W-1:0]  level_q, level_d;
    logic [3:0]          lives_q, lives_d, lives_eff;
    logic                bonus_q, bonus_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                actor_q, actor_d;
    logic                extra_q, extra_d;
    logic                award;

    // The bonus is folded into lives before any state-driven update, so a
    // bonus landing on the DYING expiry cycle is counted before the loss.
    always_comb begin
        award = (state_q != S_IDLE) && (state_q != S_GAMEOVER) && !bonus_q &&
                (i_score >= SCORE_W'(EXTRA_LIFE_SCORE));
        lives_eff = lives_q;
        if (award && (lives_q < 4'(MAX_LIVES))) begin
            lives_eff = lives_q + 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        mask_d  = mask_q;
        level_d = level_q;
        lives_d = lives_eff;
        bonus_d = bonus_q | award;
        timer_d = timer_q;
        actor_d = 1'b0;
        extra_d = award;

        case (state_q)
            S_IDLE: begin
                if (i_game_start) begin
                    state_d = S_RELOAD;
                    req_d   = '1;
                    mask_d  = '0;
                    level_d = LEVEL_W'(1);
                    lives_d = 4'(LIVES_INIT);
                    bonus_d = 1'b0;
                end
            end
            S_RELOAD: begin
                // Request drops together with the mask bit becoming visible.
                mask_d = mask_q | i_reload_done;
                req_d  = req_q & ~(mask_q | i_reload_done);
                if (mask_q == ALL_DONE) begin
                    state_d = S_READY;
                    timer_d = READY_LOAD;
                    actor_d = 1'b1;
                end
            end
            S_READY: begin
                if (timer_q == '0) begin
                    state_d = S_PLAY;
                end else if (i_tick) begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_PLAY: begin
                if (i_game_pause) begin
                    state_d = S_PAUSE;
                end else if (i_pacman_eaten) begin
                    state_d = S_DYING;
                    timer_d = DEATH_LOAD;
                end else if (i_dot_clear) begin
                    state_d = S_CLEAR;
                end
            end
            S_PAUSE: begin
                if (i_game_pause) begin
                    state_d = S_PLAY;
                end
            end
            S_DYING: begin
                if (timer_q == '0) begin
                    if (lives_eff == 4'd0) begin
                        state_d = S_GAMEOVER;
                    end else begin
                        lives_d = lives_eff - 4'd1;
                        actor_d = 1'b1;
                        state_d = S_READY;
                        timer_d = READY_LOAD;
                    end
                end else if (i_tick) begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_CLEAR: begin
                if (i_game_start) begin
                    state_d = S_RELOAD;
                    req_d   = '1;
                    mask_d  = '0;
                    if (level_q < LEVEL_W'(MAX_LEVEL)) begin
                        level_d = level_q + LEVEL_W'(1);
                    end
                end
            end
            S_GAMEOVER: begin
                if (i_game_start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            mask_q  <= '0;
            level_q <= LEVEL_W'(1);
            lives_q <= 4'(LIVES_INIT);
            bonus_q <= 1'b0;
            timer_q <= '0;
            actor_q <= 1'b0;
            extra_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            mask_q  <= mask_d;
            level_q <= level_d;
            lives_q <= lives_d;
            bonus_q <= bonus_d;
            timer_q <= timer_d;
            actor_q <= actor_d;
            extra_q <= extra_d;
        end
    end

    assign o_game_state   = state_q;
    assign o_reload_req   = req_q;
    assign o_actor_reload = actor_q;
    assign o_level        = level_q;
    assign o_lives        = lives_q;
    assign o_extra_life   = extra_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with short timers (READY 4, DYING 2)
// and a level ceiling of 3.

module tb_game_flow_ctrl;

    localparam int N_RELOAD = 2;
    localparam int SCORE_W  = 20;
    localparam int LEVEL_W  = 8;

    localparam int ST_IDLE     = 0;
    localparam int ST_RELOAD   = 1;
    localparam int ST_READY    = 2;
    localparam int ST_PLAY     = 3;
    localparam int ST_PAUSE    = 4;
    localparam int ST_DYING    = 5;
    localparam int ST_CLEAR    = 6;
    localparam int ST_GAMEOVER = 7;

    logic                i_clk = 1'b0;
    logic                i_rst_n;
    logic                i_game_start;
    logic                i_game_pause;
    logic                i_tick;
    logic [N_RELOAD-1:0] i_reload_done;
    logic                i_pacman_eaten;
    logic                i_dot_clear;
    logic [SCORE_W-1:0]  i_score;
    logic [3:0]          o_game_state;
    logic [N_RELOAD-1:0] o_reload_req;
    logic                o_actor_reload;
    logic [LEVEL_W-1:0]  o_level;
    logic [3:0]          o_lives;
    logic                o_extra_life;

    int n_chk  = 0;
    int n_fail = 0;

    game_flow_ctrl #(
        .N_RELOAD         (N_RELOAD),
        .LIVES_INIT       (3),
        .MAX_LIVES        (9),
        .LEVEL_W          (LEVEL_W),
        .MAX_LEVEL        (3),
        .READY_TICKS      (4),
        .DEATH_TICKS      (2),
        .SCORE_W          (SCORE_W),
        .EXTRA_LIFE_SCORE (10000)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_game_start   (i_game_start),
        .i_game_pause   (i_game_pause),
        .i_tick         (i_tick),
        .i_reload_done  (i_reload_done),
        .i_pacman_eaten (i_pacman_eaten),
        .i_dot_clear    (i_dot_clear),
        .i_score        (i_score),
        .o_game_state   (o_game_state),
        .o_reload_req   (o_reload_req),
        .o_actor_reload (o_actor_reload),
        .o_level        (o_level),
        .o_lives        (o_lives),
        .o_extra_life   (o_extra_life)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic tick_pulse();
        i_tick = 1'b1;
        cyc();
        i_tick = 1'b0;
    endtask

    task automatic start_pulse();
        i_game_start = 1'b1;
        cyc();
        i_game_start = 1'b0;
    endtask

    // From RELOAD: all channels done in one cycle, READY two edges later.
    task automatic reload_all();
        i_reload_done = '1;
        cyc();
        i_reload_done = '0;
        chk("reload_mask_cycle", 32'(o_game_state), ST_RELOAD);
        cyc();
        chk("reload_to_ready", 32'(o_game_state), ST_READY);
        chk("reload_actor", 32'(o_actor_reload), 1);
    endtask

    // From freshly entered READY (timer 4): four ticks, then one more cycle.
    task automatic ready_to_play();
        repeat (4) tick_pulse();
        chk("ready_last", 32'(o_game_state), ST_READY);
        cyc();
        chk("ready_to_play", 32'(o_game_state), ST_PLAY);
    endtask

    // From PLAY: get eaten, run DYING (2 ticks), take the expiry edge.
    task automatic lose_life(input int exp_state, input logic exp_actor, input bit bump_score);
        i_pacman_eaten = 1'b1;
        cyc();
        i_pacman_eaten = 1'b0;
        chk("dying_entry", 32'(o_game_state), ST_DYING);
        tick_pulse();
        tick_pulse();
        chk("dying_hold", 32'(o_game_state), ST_DYING);
        if (bump_score) i_score = SCORE_W'(10000);
        cyc();
        chk("dying_exit", 32'(o_game_state), 32'(exp_state));
        chk("dying_actor", 32'(o_actor_reload), 32'(exp_actor));
    endtask

    task automatic clear_level(input int exp_level);
        i_dot_clear = 1'b1;
        cyc();
        i_dot_clear = 1'b0;
        chk("clear_entry", 32'(o_game_state), ST_CLEAR);
        start_pulse();
        chk("clear_to_reload", 32'(o_game_state), ST_RELOAD);
        chk("clear_level", 32'(o_level), 32'(exp_level));
        chk("clear_req", 32'(o_reload_req), 3);
    endtask

    initial begin
        i_rst_n        = 1'b0;
        i_game_start   = 1'b0;
        i_game_pause   = 1'b0;
        i_tick         = 1'b0;
        i_reload_done  = '0;
        i_pacman_eaten = 1'b0;
        i_dot_clear    = 1'b0;
        i_score        = '0;

        #12;
        chk("rst_state", 32'(o_game_state), ST_IDLE);
        chk("rst_req", 32'(o_reload_req), 0);
        chk("rst_actor", 32'(o_actor_reload), 0);
        chk("rst_extra", 32'(o_extra_life), 0);
        chk("rst_level", 32'(o_level), 1);
        chk("rst_lives", 32'(o_lives), 3);
        i_rst_n = 1'b1;
        cyc();

        // Staggered reload handshake; start is cycle 0.
        start_pulse();
        chk("c1_state", 32'(o_game_state), ST_RELOAD);
        chk("c1_req", 32'(o_reload_req), 3);
        cyc();
        cyc();
        chk("c3_req", 32'(o_reload_req), 3);
        i_reload_done = 2'b01;
        cyc();
        i_reload_done = '0;
        chk("c4_req", 32'(o_reload_req), 2);
        repeat (3) cyc();
        i_reload_done = 2'b10;
        cyc();
        i_reload_done = '0;
        chk("c8_req", 32'(o_reload_req), 0);
        chk("c8_state", 32'(o_game_state), ST_RELOAD);
        cyc();
        chk("c9_state", 32'(o_game_state), ST_READY);
        chk("c9_actor", 32'(o_actor_reload), 1);
        chk("c9_level", 32'(o_level), 1);
        chk("c9_lives", 32'(o_lives), 3);
        cyc();
        chk("c10_actor", 32'(o_actor_reload), 0);

        // READY with a tick every 10 cycles; pause on the first tick is ignored.
        for (int i = 0; i < 4; i++) begin
            repeat (9) cyc();
            i_tick       = 1'b1;
            i_game_pause = (i == 0);
            cyc();
            i_tick       = 1'b0;
            i_game_pause = 1'b0;
            chk("ready_hold", 32'(o_game_state), ST_READY);
        end
        cyc();
        chk("ready_expire", 32'(o_game_state), ST_PLAY);

        // Pause wins over eaten; eaten ignored while paused.
        i_game_pause   = 1'b1;
        i_pacman_eaten = 1'b1;
        cyc();
        i_game_pause   = 1'b0;
        chk("pause_prio", 32'(o_game_state), ST_PAUSE);
        cyc();
        i_pacman_eaten = 1'b0;
        chk("pause_ignore_eaten", 32'(o_game_state), ST_PAUSE);
        i_game_pause = 1'b1;
        cyc();
        i_game_pause = 1'b0;
        chk("unpause", 32'(o_game_state), ST_PLAY);

        lose_life(ST_READY, 1'b1, 1'b0);
        chk("lives_3_to_2", 32'(o_lives), 2);
        ready_to_play();
        lose_life(ST_READY, 1'b1, 1'b0);
        chk("lives_1", 32'(o_lives), 1);
        ready_to_play();
        lose_life(ST_READY, 1'b1, 1'b0);
        chk("lives_0", 32'(o_lives), 0);
        ready_to_play();
        start_pulse();
        chk("start_ignored_play", 32'(o_game_state), ST_PLAY);
        lose_life(ST_GAMEOVER, 1'b0, 1'b0);
        chk("gameover_lives", 32'(o_lives), 0);
        start_pulse();
        chk("gameover_to_idle", 32'(o_game_state), ST_IDLE);
        start_pulse();
        chk("newgame_state", 32'(o_game_state), ST_RELOAD);
        chk("newgame_lives", 32'(o_lives), 3);
        chk("newgame_level", 32'(o_level), 1);

        // Second game: drain lives, then the bonus lands on the DYING expiry.
        reload_all();
        ready_to_play();
        for (int i = 0; i < 3; i++) begin
            lose_life(ST_READY, 1'b1, 1'b0);
            ready_to_play();
        end
        chk("g2_lives_0", 32'(o_lives), 0);
        lose_life(ST_READY, 1'b1, 1'b1);
        chk("bonus_pulse", 32'(o_extra_life), 1);
        chk("bonus_lives", 32'(o_lives), 0);
        cyc();
        chk("bonus_pulse_end", 32'(o_extra_life), 0);
        i_score = '0;
        cyc();
        i_score = SCORE_W'(10000);
        cyc();
        chk("bonus_once_a", 32'(o_extra_life), 0);
        cyc();
        chk("bonus_once_b", 32'(o_extra_life), 0);
        chk("bonus_once_lives", 32'(o_lives), 0);

        // Level progression with saturation at 3.
        ready_to_play();
        clear_level(2);
        chk("clear_lives_kept", 32'(o_lives), 0);
        reload_all();
        ready_to_play();
        clear_level(3);
        reload_all();
        ready_to_play();
        clear_level(3);

        // Asynchronous reset in the middle of RELOAD.
        i_reload_done = 2'b01;
        cyc();
        i_reload_done = '0;
        chk("mid_reload_req", 32'(o_reload_req), 2);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(o_game_state), ST_IDLE);
        chk("async_rst_req", 32'(o_reload_req), 0);
        chk("async_rst_level", 32'(o_level), 1);
        chk("async_rst_lives", 32'(o_lives), 3);
        #2;
        i_rst_n = 1'b1;
        cyc();
        chk("post_rst_idle", 32'(o_game_state), ST_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
